alu_ctrl_seq: RTL and testbench

//  Parametrised, registered ALU controller for the pipelined LEGv8 core. Decodes ALUOp plus

---
 rtl/alu_ctrl_pkg.sv | 35 +++
 rtl/alu_ctrl_decode.sv | 73 +++++++
 rtl/alu_ctrl_seq.sv | 97 +++++++++
 tb/tb_alu_ctrl_seq.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_ctrl_pkg.sv
// Shared constants for the LEGv8 ALU controller: ALU codes, R-type opcodes, divide selectors, FSM states.
package alu_ctrl_pkg;

    localparam logic [3:0] CODE_AND   = 4'b0000;
    localparam logic [3:0] CODE_ORR   = 4'b0001;
    localparam logic [3:0] CODE_ADD   = 4'b0010;
    localparam logic [3:0] CODE_SUB   = 4'b0110;
    localparam logic [3:0] CODE_PASSB = 4'b0111;
    localparam logic [3:0] CODE_MUL   = 4'b1000;
    localparam logic [3:0] CODE_SDIV  = 4'b1001;
    localparam logic [3:0] CODE_UDIV  = 4'b1010;

    localparam logic [10:0] OPC_ADD  = 11'b10001011000;
    localparam logic [10:0] OPC_SUB  = 11'b11001011000;
    localparam logic [10:0] OPC_AND  = 11'b10001010000;
    localparam logic [10:0] OPC_ORR  = 11'b10101010000;
    localparam logic [10:0] OPC_ADDS = 11'b10101011000;
    localparam logic [10:0] OPC_SUBS = 11'b11101011000;
    localparam logic [10:0] OPC_MUL  = 11'b10011011000;
    localparam logic [10:0] OPC_DIV  = 11'b10011010110;

    localparam logic [5:0] SHAMT_SDIV = 6'b000010;
    localparam logic [5:0] SHAMT_UDIV = 6'b000011;

    localparam logic [1:0] ALUOP_MEM = 2'b00;
    localparam logic [1:0] ALUOP_CBZ = 2'b01;
    localparam logic [1:0] ALUOP_R   = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_MULTI = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational ALUOp/opcode/shamt decode. SDIV/UDIV are recognised only when ALU_CTRL_DIV_EN is defined;
// otherwise they fall through to the illegal path.
module alu_ctrl_decode
    import alu_ctrl_pkg::*;
#(
    parameter int OPC_W  = 11,
    parameter int FUNC_W = 6,
    parameter int CODE_W = 4
) (
    input  logic [1:0]        alu_op,
    input  logic [OPC_W-1:0]  opcode,
    input  logic [FUNC_W-1:0] shamt,
    output logic [CODE_W-1:0] code,
    output logic              set_flags,
    output logic              multi,
    output logic              is_div,
    output logic              illegal
);

`ifndef ALU_CTRL_DIV_EN
    logic w_unused_shamt;
    assign w_unused_shamt = ^shamt;
`endif

    always_comb begin
        code      = CODE_W'(CODE_ADD);
        set_flags = 1'b0;
        multi     = 1'b0;
        is_div    = 1'b0;
        illegal   = 1'b0;
        case (alu_op)
            ALUOP_MEM: ;
            ALUOP_CBZ: code = CODE_W'(CODE_PASSB);
            ALUOP_R: begin
                case (opcode)
                    OPC_W'(OPC_ADD):  ;
                    OPC_W'(OPC_SUB):  code = CODE_W'(CODE_SUB);
                    OPC_W'(OPC_AND):  code = CODE_W'(CODE_AND);
                    OPC_W'(OPC_ORR):  code = CODE_W'(CODE_ORR);
                    OPC_W'(OPC_ADDS): set_flags = 1'b1;
                    OPC_W'(OPC_SUBS): begin
                        code      = CODE_W'(CODE_SUB);
                        set_flags = 1'b1;
                    end
                    OPC_W'(OPC_MUL): begin
                        code  = CODE_W'(CODE_MUL);
                        multi = 1'b1;
                    end
                    OPC_W'(OPC_DIV): begin
`ifdef ALU_CTRL_DIV_EN
                        if (shamt == FUNC_W'(SHAMT_SDIV)) begin
                            code   = CODE_W'(CODE_SDIV);
                            multi  = 1'b1;
                            is_div = 1'b1;
                        end else if (shamt == FUNC_W'(SHAMT_UDIV)) begin
                            code   = CODE_W'(CODE_UDIV);
                            multi  = 1'b1;
                            is_div = 1'b1;
                        end else begin
                            illegal = 1'b1;
                        end
`else
                        illegal = 1'b1;
`endif
                    end
                    default: illegal = 1'b1;
                endcase
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_ctrl_seq.sv
// Registered ALU controller: IDLE/MULTI/HOLD handshake FSM that holds the op code while MUL/DIV iterate.
// Optional divide support via ALU_CTRL_DIV_EN (see alu_ctrl_decode).
module alu_ctrl_seq
    import alu_ctrl_pkg::*;
#(
    parameter int OPC_W      = 11,
    parameter int FUNC_W     = 6,
    parameter int CODE_W     = 4,
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        alu_op,
    input  logic [OPC_W-1:0]  opcode,
    input  logic [FUNC_W-1:0] shamt,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CODE_W-1:0] code,
    output logic              set_flags,
    output logic              busy,
    output logic              illegal
);

    localparam int MAX_CYC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = (MAX_CYC > 2) ? $clog2(MAX_CYC) : 1;
    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 2);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 2);

    state_t            r_state, w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [CODE_W-1:0] r_code;
    logic              r_set_flags, r_illegal;

    logic [CODE_W-1:0] w_code;
    logic              w_set_flags, w_multi, w_is_div, w_illegal, w_accept;

    alu_ctrl_decode #(
        .OPC_W  (OPC_W),
        .FUNC_W (FUNC_W),
        .CODE_W (CODE_W)
    ) u_decode (
        .alu_op    (alu_op),
        .opcode    (opcode),
        .shamt     (shamt),
        .code      (w_code),
        .set_flags (w_set_flags),
        .multi     (w_multi),
        .is_div    (w_is_div),
        .illegal   (w_illegal)
    );

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = (r_state == S_IDLE) || ((r_state == S_HOLD) && out_ready);
        w_accept    = in_valid && in_ready;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_nxt = w_multi ? S_MULTI : S_HOLD;
            S_MULTI: if (r_cnt == '0) w_state_nxt = S_HOLD;
            S_HOLD: begin
                if (w_accept)       w_state_nxt = w_multi ? S_MULTI : S_HOLD;
                else if (out_ready) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Counter is only loaded on accept, so it never wraps; it parks at 0 outside MULTI.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_code      <= CODE_W'(CODE_ADD);
            r_set_flags <= 1'b0;
            r_illegal   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_code      <= w_code;
                r_set_flags <= w_set_flags;
                r_illegal   <= w_illegal;
                r_cnt       <= w_multi ? (w_is_div ? DIV_LOAD : MUL_LOAD) : '0;
            end else if ((r_state == S_MULTI) && (r_cnt != '0)) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
        end
    end

    assign out_valid = (r_state == S_HOLD);
    assign busy      = (r_state == S_MULTI);
    assign code      = r_code;
    assign set_flags = r_set_flags;
    assign illegal   = r_illegal;

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Scoreboard bench for alu_ctrl_seq: stimulus pushes expected results, a monitor pops and compares.
module tb_alu_ctrl_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  alu_op = 2'b00;
    logic [10:0] opcode = '0;
    logic [5:0]  shamt = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [3:0]  code;
    logic        set_flags, busy, illegal;

    alu_ctrl_seq #(
        .OPC_W(11), .FUNC_W(6), .CODE_W(4), .MUL_CYCLES(4), .DIV_CYCLES(16)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .alu_op(alu_op), .opcode(opcode), .shamt(shamt),
        .out_valid(out_valid), .out_ready(out_ready), .code(code),
        .set_flags(set_flags), .busy(busy), .illegal(illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] code;
        logic       sf;
        logic       ill;
        int         acc;
        int         lat;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   ncyc = 0;
    bit   seen = 1'b0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, ncyc);
        end
    endfunction

    initial forever begin
        @(negedge clk);
        ncyc++;
    end

    // Monitor: stable outputs are re-checked every HOLD cycle; pop on handshake.
    initial forever begin
        exp_t e;
        @(negedge clk);
        #3;
        if (!rst && out_valid) begin
            if (sb.size() == 0) begin
                check("unexpected_out_valid", 32'(out_valid), 32'd0);
            end else begin
                e = sb[0];
                check("code", 32'(code), 32'(e.code));
                check("set_flags", 32'(set_flags), 32'(e.sf));
                check("illegal", 32'(illegal), 32'(e.ill));
                if (!seen) check("latency", 32'(ncyc - e.acc), 32'(e.lat));
                seen = 1'b1;
                if (out_ready) begin
                    void'(sb.pop_front());
                    seen = 1'b0;
                end
            end
        end
    end

    task automatic issue(input logic [1:0] op, input logic [10:0] opc, input logic [5:0] sh,
                         input logic [3:0] c, input logic sf, input logic ill, input int lat,
                         output int waited);
        exp_t e;
        waited = 0;
        @(negedge clk);
        #1;
        in_valid = 1'b1; alu_op = op; opcode = opc; shamt = sh;
        #1;
        while (!in_ready && waited < 60) begin
            @(negedge clk);
            #2;
            waited++;
        end
        if (!in_ready) begin
            check("accept_timeout", 32'(in_ready), 32'd1);
        end else begin
            e.code = c; e.sf = sf; e.ill = ill; e.acc = ncyc; e.lat = lat;
            sb.push_back(e);
        end
    endtask

    task automatic idle();
        @(negedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("drain_queue_empty", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        repeat (2) @(negedge clk);
        #2;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_code", 32'(code), 32'b0010);
        check("rst_set_flags", 32'(set_flags), 32'd0);
        check("rst_illegal", 32'(illegal), 32'd0);
        @(negedge clk);
        #1;
        rst = 1'b0;

        // SUB then a back-to-back ADD/AND/ORR stream
        issue(2'b10, 11'b11001011000, 6'd0, 4'b0110, 1'b0, 1'b0, 1, w);
        issue(2'b10, 11'b10001011000, 6'd0, 4'b0010, 1'b0, 1'b0, 1, w);
        check("stream_wait_add", 32'(w), 32'd0);
        issue(2'b10, 11'b10001010000, 6'd0, 4'b0000, 1'b0, 1'b0, 1, w);
        check("stream_wait_and", 32'(w), 32'd0);
        issue(2'b10, 11'b10101010000, 6'd0, 4'b0001, 1'b0, 1'b0, 1, w);
        check("stream_wait_orr", 32'(w), 32'd0);

        // Flag-setting ops, CBZ, load/store, alu_op=11
        issue(2'b10, 11'b11101011000, 6'd0, 4'b0110, 1'b1, 1'b0, 1, w);
        issue(2'b10, 11'b10101011000, 6'd0, 4'b0010, 1'b1, 1'b0, 1, w);
        issue(2'b01, 11'b11001011000, 6'd0, 4'b0111, 1'b0, 1'b0, 1, w);
        issue(2'b00, 11'b10011011000, 6'd0, 4'b0010, 1'b0, 1'b0, 1, w);
        issue(2'b11, 11'b10001011000, 6'd0, 4'b0010, 1'b0, 1'b1, 1, w);
        idle();
        drain();

        // MUL: busy for 3 cycles with a waiting ADD held off
        issue(2'b10, 11'b10011011000, 6'd0, 4'b1000, 1'b0, 1'b0, 4, w);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            alu_op = 2'b10; opcode = 11'b10001011000; shamt = 6'd0; in_valid = 1'b1;
            #1;
            check("mul_busy", 32'(busy), 32'd1);
            check("mul_in_ready", 32'(in_ready), 32'd0);
            check("mul_out_valid", 32'(out_valid), 32'd0);
        end
        issue(2'b10, 11'b10001011000, 6'd0, 4'b0010, 1'b0, 1'b0, 1, w);
        check("mul_then_add_wait", 32'(w), 32'd0);
        check("mul_hold_busy", 32'(busy), 32'd0);
        idle();
        drain();

        // Divide encodings
`ifdef ALU_CTRL_DIV_EN
        issue(2'b10, 11'b10011010110, 6'b000011, 4'b1010, 1'b0, 1'b0, 16, w);
        issue(2'b10, 11'b10011010110, 6'b000010, 4'b1001, 1'b0, 1'b0, 16, w);
`else
        issue(2'b10, 11'b10011010110, 6'b000011, 4'b0010, 1'b0, 1'b1, 1, w);
        issue(2'b10, 11'b10011010110, 6'b000010, 4'b0010, 1'b0, 1'b1, 1, w);
`endif
        issue(2'b10, 11'b10011010110, 6'b000001, 4'b0010, 1'b0, 1'b1, 1, w);
        idle();
        drain();

        // Undefined opcode held in HOLD for 5 cycles
        @(negedge clk);
        #1;
        out_ready = 1'b0;
        issue(2'b10, 11'b11111111111, 6'd0, 4'b0010, 1'b0, 1'b1, 1, w);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            in_valid = 1'b0;
            #1;
            check("hold_in_ready", 32'(in_ready), 32'd0);
            check("hold_out_valid", 32'(out_valid), 32'd1);
        end
        @(negedge clk);
        #1;
        out_ready = 1'b1;
        drain();

        // Reset during MULTI cycle 2
        issue(2'b10, 11'b10011011000, 6'd0, 4'b1000, 1'b0, 1'b0, 4, w);
        @(negedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        #1;
        check("pre_rst_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        sb.delete();
        seen = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_code", 32'(code), 32'b0010);
        check("abort_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        #1;
        rst = 1'b0;
        repeat (6) @(negedge clk);
        #2;
        check("post_rst_out_valid", 32'(out_valid), 32'd0);
        check("post_rst_busy", 32'(busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
